// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-cell counter slice.
//   jk_cmd_e     : 2-bit JK excitation command, encoded as {J,K}
//   jk_clamp_max : largest legal count for a given modulus (load clamp value)
// ---------------------------------------------------------------------------
package jk_pkg;

   // Encoding is {J,K} so a command drives the cell inputs bit-for-bit.
   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_e;

   // Top of the count range; out-of-range load values clamp to this.
   function automatic int jk_clamp_max(input int modulus);
      return modulus - 32'sd1;
   endfunction

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One JK storage bit with true and complement outputs.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (q=0, qb=1)
//   j    in  J excitation
//   k    in  K excitation
//   q    out true output
//   qb   out complement output, registered alongside q
// ---------------------------------------------------------------------------
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic q_q;
   logic qb_q;
   logic q_d;

   // JK characteristic equation: hold, reset, set or toggle.
   always_comb begin
      q_d = q_q;
      case ({j, k})
         JK_HOLD:   q_d = q_q;
         JK_RESET:  q_d = 1'b0;
         JK_SET:    q_d = 1'b1;
         JK_TOGGLE: q_d = ~q_q;
         default:   q_d = q_q;
      endcase
   end

   // Storage flops; qb is its own flop so it changes on the same edge as q.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q  <= 1'b0;
         qb_q <= 1'b1;
      end else begin
         q_q  <= q_d;
         qb_q <= ~q_d;
      end
   end

   assign q  = q_q;
   assign qb = qb_q;

endmodule : jk_cell

// File: rtl/jk_counter.sv
// ---------------------------------------------------------------------------
// jk_counter
// Synchronous mod-MODULUS up/down counter built from WIDTH jk_cell bits.
// This module only computes the next count, the per-bit JK excitation, the
// load clamp, terminal count and the wrap pulse; the count lives in the cells.
// Optional build macro:
//   JK_CNT_SAT_EN  saturate at the range boundary instead of wrapping;
//                  wrapped is then constant 0.
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset
//   en       in  count enable
//   up       in  direction (1 = up, 0 = down)
//   load     in  parallel load, priority over en
//   din      in  load value (clamped to MODULUS-1)
//   q        out count (true outputs of the cells)
//   qb       out complement outputs
//   tc       out combinational terminal count
//   wrapped  out registered one-cycle wrap pulse
// ---------------------------------------------------------------------------
module jk_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(jk_clamp_max(MODULUS));
   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);

   jk_cmd_e          cmd [WIDTH];
   logic [WIDTH-1:0] target;
   logic             at_max;
   logic             at_zero;
   logic             din_ok;
   logic             wrapped_d;
   logic             wrapped_q;

   assign at_max  = (q == MAX_VAL);
   assign at_zero = (q == ZERO_VAL);
   assign din_ok  = ({1'b0, din} < MOD_EXT);
   assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));

   // Next count and JK excitation: load uses SET/RESET, counting only toggles.
   always_comb begin
      target    = q;
      wrapped_d = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         cmd[i] = JK_HOLD;
      end
      if (load) begin
         target = din_ok ? din : MAX_VAL;
         for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = target[i] ? JK_SET : JK_RESET;
         end
      end else if (en) begin
         if (up) begin
            if (at_max) begin
`ifdef JK_CNT_SAT_EN
               target = q;
`else
               target    = ZERO_VAL;
               wrapped_d = 1'b1;
`endif
            end else begin
               target = q + ONE_VAL;
            end
         end else begin
            if (at_zero) begin
`ifdef JK_CNT_SAT_EN
               target = q;
`else
               target    = MAX_VAL;
               wrapped_d = 1'b1;
`endif
            end else begin
               target = q - ONE_VAL;
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = (target[i] != q[i]) ? JK_TOGGLE : JK_HOLD;
         end
      end else begin
         target = q;
      end
   end

   // Wrap pulse register; rst and load both clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrapped_q <= 1'b0;
      end else begin
         wrapped_q <= wrapped_d;
      end
   end

   assign wrapped = wrapped_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      logic [1:0] cmd_bits;
      assign cmd_bits = cmd[g];
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (cmd_bits[1]),
         .k   (cmd_bits[0]),
         .q   (q[g]),
         .qb  (qb[g])
      );
   end

endmodule : jk_counter

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, MODULUS=10).
module tb_jk_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             up = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             tc;
   logic             wrapped;

   always #5 clk = ~clk;

   jk_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up      (up),
      .load    (load),
      .din     (din),
      .q       (q),
      .qb      (qb),
      .tc      (tc),
      .wrapped (wrapped)
   );

   typedef struct {
      bit               chk_tc;
      logic             tc;
      logic [WIDTH-1:0] q;
      logic             wrapped;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   m_cnt = 0;
   bit   m_known = 1'b0;
   exp_t mon_item;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: count arithmetic straight from the rules, modulo MODULUS.
   task automatic step(input logic r, input logic ld, input logic e, input logic u,
                       input logic [WIDTH-1:0] d);
      exp_t x;
      int   nxt;
      logic w;
      @(negedge clk);
      rst = r; load = ld; en = e; up = u; din = d;
      x.chk_tc = m_known;
      x.tc = e && !ld && ((u && m_cnt == MODULUS - 1) || (!u && m_cnt == 0));
      w = 1'b0;
      nxt = m_cnt;
      if (r) begin
         nxt = 0;
      end else if (ld) begin
         nxt = (int'(d) < MODULUS) ? int'(d) : MODULUS - 1;
      end else if (e) begin
`ifdef JK_CNT_SAT_EN
         if (u) nxt = (m_cnt == MODULUS - 1) ? m_cnt : m_cnt + 1;
         else   nxt = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
         if (u) begin
            nxt = (m_cnt + 1) % MODULUS;
            w = (m_cnt == MODULUS - 1);
         end else begin
            nxt = (m_cnt + MODULUS - 1) % MODULUS;
            w = (m_cnt == 0);
         end
`endif
      end
      m_cnt = nxt;
      if (r || ld) m_known = 1'b1;
      x.q = nxt[WIDTH-1:0];
      x.wrapped = w;
      sb.push_back(x);
   endtask

   // Monitor: tc checked mid-cycle with inputs applied, state checked after edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            if (mon_item.chk_tc) chk("tc", {31'd0, tc}, {31'd0, mon_item.tc});
            @(posedge clk);
            #1;
            chk("q", {28'd0, q}, {28'd0, mon_item.q});
            chk("qb", {28'd0, qb}, {28'd0, ~mon_item.q});
            chk("wrapped", {31'd0, wrapped}, {31'd0, mon_item.wrapped});
         end
      end
   end

   initial begin
      // reset, then count up through the wrap
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      // down-count wrap from 3
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      // load clamp with en, then rst beats load
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
      // hold at 7
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      // reset mid-count at 6
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      // boundary loads around the clamp point
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd10);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_jk_counter
